seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised multi-cycle shifter for the datapath. It generalises the fixed shift-left-by-2 to any width, any shift amount and four shift modes. It retires a configurable number of bit positions per clock under a start/busy/done handshake. Used where a single-cycle barrel shifter costs too much area, e.g. the SLLV/SRLV/SRAV path and address scaling.

## Interface
Parameters:
- n, 32: data width in bits; n ≥ 2.
- STEP, 1: bit positions retired per SHIFT cycle; 1 ≤ STEP ≤ n.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy = 0.
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
- A  input  n  operand; sampled on the accepted start.
- shamt  input  $clog2(n)  shift amount; sampled on the accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse in DONE.
- C  output  n  result register; valid from DONE until the next accepted start.

## Operation
- States:
  - IDLE: busy=0, done=0. Accepted start latches acc←A, rem←shamt and the mode. Next state is SHIFT if shamt≠0, otherwise DONE.
  - SHIFT: each cycle k = min(STEP, rem); acc is shifted by k in the latched mode; rem←rem−k. The state goes to DONE when rem−k = 0.
  - DONE: done=1, busy=1. The state always goes to IDLE next cycle.
- Shift rules, applied per step of k bits:
  - SLL: zero fill on the right.
  - SRL: zero fill on the left.
  - SRA: replicate acc[n-1].
  - ROL: bits leaving at the MSB re-enter at the LSB.
- C is driven directly from acc. It holds its value through IDLE until the next accepted start.
- start while busy=1, including during DONE, is ignored. There is no queueing.
- A, shamt and mode may change freely after acceptance without affecting the operation.
- Reset values: state=IDLE, acc=0, rem=0, C=0, busy=0, done=0.
- reset asserted mid-operation aborts the operation. The next cycle shows the reset values; no done pulse is produced.

## Timing
- Start accepted at edge 0 gives S = ceil(shamt/STEP) SHIFT cycles, then one DONE cycle.
- done is high during cycle S+1 after the accepting edge. For shamt=0, done is high in the cycle immediately after the accepting edge and C = A.
- busy rises the cycle after the accepting edge and falls the cycle after DONE. The earliest next start is therefore S+2 cycles after the previous one.
- C is stable and correct whenever done=1.

## Structure
- Package shift_pkg:
  - typedef enum logic [1:0] shift_mode_t {SLL, SRL, SRA, ROL}.
  - typedef enum state_t {IDLE, SHIFT, DONE}.
- Sub-module shift_step: purely combinational, parameters n and STEP. Inputs are acc, k and mode; output is acc shifted by k. The FSM and registers stay in seq_shifter.

## Test plan
- n=32, STEP=1, SLL, A=0x0000_0001, shamt=2 → done in cycle 3 after accept, C=0x0000_0004. This matches legacy shift-left-by-2 behaviour for random A.
- STEP=1, SRA, A=0x8000_0000, shamt=4 → C=0xF800_0000. ROL, A=0x8000_0001, shamt=1 → C=0x0000_0003.
- STEP=8, SRL, A=0xDEAD_BEEF, shamt=20 → 3 SHIFT cycles (8,8,4), done in cycle 4, C=0x0000_0DEA.
- shamt=0, any mode, A=0x1234_5678 → done in the next cycle, C=0x1234_5678, busy high for exactly one cycle.
- start pulsed during SHIFT with a different A → ignored; the first result is unchanged. A new start in the cycle after done falls → accepted.
- reset asserted in the 2nd SHIFT cycle of a shamt=10 op → next cycle C=0, busy=0, done=0. No done pulse is ever seen for that op.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shifter.
//   shift_mode_t : operation selected by the 2-bit mode input
//   state_t      : sequencer states of seq_shifter
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to STEP bit positions.
// Ports:
//   acc    : value to be shifted (n bits)
//   k      : number of positions for this step, 0..STEP
//   mode   : SLL / SRL / SRA / ROL
//   result : acc shifted by k positions in the selected mode
module shift_step
  import shift_pkg::*;
#(
  parameter int n    = 32,
  parameter int STEP = 1,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [n-1:0]  acc,
  input  logic [KW-1:0] k,
  input  shift_mode_t   mode,
  output logic [n-1:0]  result
);

  logic [2*n-1:0] rot_wide;

  // The rotate is formed by shifting a doubled copy of acc left; the upper
  // half then holds the bits that wrapped around from the MSB into the LSB.
  always_comb begin
    rot_wide = {acc, acc} << k;
    case (mode)
      SLL:     result = acc << k;
      SRL:     result = acc >> k;
      SRA:     result = $signed(acc) >>> k;
      ROL:     result = rot_wide[2*n-1:n];
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: retires up to STEP bit positions per clock until the
// requested shift amount is used up, under a start/busy/done handshake.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset
//   start  : request, only accepted while busy is low
//   mode   : 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   A      : operand, captured on the accepted start
//   shamt  : shift amount, captured on the accepted start
//   busy   : high while shifting and in the done cycle
//   done   : one-cycle completion pulse
//   C      : result, held until the next accepted start
module seq_shifter
  import shift_pkg::*;
#(
  parameter int n    = 32,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [n-1:0]         A,
  input  logic [$clog2(n)-1:0] shamt,
  output logic                 busy,
  output logic                 done,
  output logic [n-1:0]         C
);

  localparam int SW = $clog2(n);
  localparam int KW = $clog2(STEP + 1);

  state_t      state, state_next;
  logic [n-1:0]  acc, acc_next, stepped;
  logic [SW-1:0] rem, rem_next, rem_after;
  logic [KW-1:0] k;
  shift_mode_t mode_q, mode_next;

  // Size of the current step: a full STEP, or whatever is left if smaller.
  always_comb begin
    if (32'(rem) >= STEP) k = KW'(STEP);
    else                  k = KW'(rem);
    rem_after = rem - SW'(k);
  end

  shift_step #(.n(n), .STEP(STEP)) u_step (
    .acc    (acc),
    .k      (k),
    .mode   (mode_q),
    .result (stepped)
  );

  // Sequencer: IDLE captures the operands, SHIFT walks acc towards the result
  // one step per cycle, DONE flags completion for exactly one cycle.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    rem_next   = rem;
    mode_next  = mode_q;
    case (state)
      IDLE: begin
        if (start) begin
          acc_next   = A;
          rem_next   = shamt;
          mode_next  = shift_mode_t'(mode);
          state_next = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        acc_next = stepped;
        rem_next = rem_after;
        if (rem_after == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      mode_q <= SLL;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      rem    <= rem_next;
      mode_q <= mode_next;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign C    = acc;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter, with one instance retiring one bit per
// cycle and one retiring eight bits per cycle.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start8;
  logic [1:0]  mode;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic        busy1, done1, busy8, done8;
  logic [31:0] c1, c8;

  int errors = 0;
  int checks = 0;

  seq_shifter #(.n(32), .STEP(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode), .A(A),
    .shamt(shamt), .busy(busy1), .done(done1), .C(c1)
  );

  seq_shifter #(.n(32), .STEP(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode), .A(A),
    .shamt(shamt), .busy(busy8), .done(done8), .C(c8)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference: the complete shift in one go, from the mode definitions.
  function automatic logic [31:0] refShift(input logic [1:0] m, input logic [31:0] a,
                                           input logic [4:0] sh);
    logic [63:0] p;
    logic [31:0] r;
    p = 64'd1;
    repeat (sh) p = p * 64'd2;
    r = a;
    case (m)
      2'b00: r = 32'(64'(a) * p);
      2'b01: r = 32'(64'(a) / p);
      2'b10: repeat (sh) r = {r[31], r[31:1]};
      default: repeat (sh) r = {r[30:0], r[31]};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setStart(input int which, input logic v);
    if (which == 8) start8 = v;
    else            start1 = v;
  endtask

  // Issues one operation from a negedge, scrambles the inputs after
  // acceptance, then checks latency, result, busy span and the hold of C.
  // With intrude set, a conflicting start is pulsed in the 2nd SHIFT cycle.
  task automatic applyStimulus(input string tag, input int which, input logic [1:0] m,
                               input logic [31:0] a, input logic [4:0] sh,
                               input logic [31:0] expected, input bit intrude);
    int expS, cyc, busyCount;
    bit seenDone;
    expS = (int'(sh) + which - 1) / which;
    mode = m; A = a; shamt = sh;
    setStart(which, 1'b1);
    @(posedge clk); #1;
    setStart(which, 1'b0);
    A = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    cyc = 0; busyCount = 0; seenDone = 1'b0;
    while (!seenDone && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if ((which == 8) ? busy8 : busy1) busyCount++;
      if ((which == 8) ? done8 : done1) seenDone = 1'b1;
      else if (intrude && cyc == 2) begin
        A = ~a; shamt = 5'd1;
        setStart(which, 1'b1);
      end else setStart(which, 1'b0);
    end
    setStart(which, 1'b0);
    checkOutput({tag, " latency"}, 32'(cyc), 32'(expS + 1));
    checkOutput({tag, " C"}, (which == 8) ? c8 : c1, expected);
    checkOutput({tag, " busyCycles"}, 32'(busyCount), 32'(expS + 1));
    @(negedge clk);
    checkOutput({tag, " busyAfter"}, 32'((which == 8) ? busy8 : busy1), 32'd0);
    checkOutput({tag, " Chold"}, (which == 8) ? c8 : c1, expected);
  endtask

  // Directed steps first, then randomized operations against the model,
  // and finally an aborted operation.
  initial begin
    logic [31:0] ra;
    logic [4:0]  rs;
    logic [1:0]  rm;
    int          w;
    bit          sawDone;

    reset = 1'b1; start1 = 1'b0; start8 = 1'b0;
    mode = 2'b00; A = '0; shamt = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset C1", c1, 32'd0);
    checkOutput("reset busy1", 32'(busy1), 32'd0);
    checkOutput("reset done1", 32'(done1), 32'd0);
    checkOutput("reset C8", c8, 32'd0);
    checkOutput("reset busy8", 32'(busy8), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("sll1by2", 1, 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 1'b0);
    ra = $urandom;
    applyStimulus("legacySll2", 1, 2'b00, ra, 5'd2, ra * 32'd4, 1'b0);
    applyStimulus("sra4", 1, 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    applyStimulus("rol1", 1, 2'b11, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b0);
    applyStimulus("srl20step8", 8, 2'b01, 32'hDEAD_BEEF, 5'd20, 32'h0000_0DEA, 1'b0);
    applyStimulus("zero1", 1, 2'b10, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0);
    applyStimulus("zero8", 8, 2'b11, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0);
    applyStimulus("sra31step8", 8, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("rol31step8", 8, 2'b11, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    applyStimulus("intrude", 1, 2'b00, 32'h0000_00F0, 5'd6, 32'h0000_3C00, 1'b1);
    applyStimulus("backToBack", 1, 2'b01, 32'hF000_0000, 5'd3, 32'h1E00_0000, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rs = 5'($urandom); rm = 2'($urandom);
      w  = (i % 2 == 0) ? 1 : 8;
      applyStimulus($sformatf("rand%0d", i), w, rm, ra, rs, refShift(rm, ra, rs), 1'b0);
    end

    mode = 2'b00; A = 32'h0000_0001; shamt = 5'd10;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort C1", c1, 32'd0);
    checkOutput("abort busy1", 32'(busy1), 32'd0);
    checkOutput("abort done1", 32'(done1), 32'd0);
    checkOutput("abort C8", c8, 32'd0);
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done1) sawDone = 1'b1;
    end
    checkOutput("abort noDone", 32'(sawDone), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
